// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the tdm_mux channel selector.
// Optional parity output is controlled by the TDM_MUX_PARITY_EN macro.
package tdm_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Event priority within one clock cycle, highest first (lowest number wins).
    localparam int PRIO_RST      = 0;
    localparam int PRIO_BLANK    = 1;
    localparam int PRIO_MODE_CHG = 2;
    localparam int PRIO_HOLD     = 3;
    localparam int PRIO_ADVANCE  = 4;

    // Smallest r with (1 << r) >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_mux_if.sv
// Channel-data and output bundle for tdm_mux.
// The master side drives din/en/mode/sel/hold and observes the registered outputs.
// With TDM_MUX_PARITY_EN defined the bundle also carries z_par.
interface tdm_mux_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
);
    localparam int SELW = tdm_mux_pkg::clog2(NCH);

    logic [NCH*WIDTH-1:0] din;
    logic                 en;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic                 hold;

    logic [WIDTH-1:0]     z;
    logic                 z_valid;
    logic [SELW-1:0]      ch;
    logic                 frame_start;

`ifdef TDM_MUX_PARITY_EN
    logic                 z_par;

    modport master (
        output din, en, mode, sel, hold,
        input  z, z_valid, ch, frame_start, z_par
    );

    modport slave (
        input  din, en, mode, sel, hold,
        output z, z_valid, ch, frame_start, z_par
    );
`else
    modport master (
        output din, en, mode, sel, hold,
        input  z, z_valid, ch, frame_start
    );

    modport slave (
        input  din, en, mode, sel, hold,
        output z, z_valid, ch, frame_start
    );
`endif

endinterface

// File: rtl/tdm_mux_scan_ctr.sv
// Auto-scan position tracker for tdm_mux.
//
//   register  | meaning
//   ----------+-----------------------------------------------------------
//   r_ch_q    | channel the scan is currently presenting
//   r_dwell_q | cycles already spent on r_ch_q (0..DWELL-1)
//   r_first_q | next auto sample is the first of a frame (channel 0)
//   r_mode_d  | mode seen last cycle, used to spot manual->auto entry
//
// o_ch_cur/o_first_cur are the values the current cycle runs with: the
// registered scan state, or the entry load on a manual->auto transition.
module tdm_scan_ctr
    import tdm_mux_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_mode,
    input  logic [clog2(NCH)-1:0]   i_sel,
    input  logic                    i_hold,
    output logic [clog2(NCH)-1:0]   o_ch_cur,
    output logic                    o_first_cur
);
    localparam int SELW = clog2(NCH);
    localparam int DW   = clog2(DWELL + 1);

    localparam logic [SELW-1:0] CH_LAST    = SELW'(NCH - 1);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);

    logic [SELW-1:0] r_ch_q;
    logic [DW-1:0]   r_dwell_q;
    logic            r_first_q;
    logic            r_mode_d;

    logic            w_entry;
    logic [SELW-1:0] w_ch_cur;
    logic [DW-1:0]   w_dwell_cur;
    logic            w_first_cur;

    logic [SELW-1:0] w_ch_n;
    logic [DW-1:0]   w_dwell_n;
    logic            w_first_n;

    // Effective scan state for this cycle, including the manual->auto entry load.
    always_comb begin
        w_entry     = (i_mode == MODE_AUTO) && (r_mode_d == MODE_MANUAL);
        w_ch_cur    = r_ch_q;
        w_dwell_cur = r_dwell_q;
        w_first_cur = r_first_q;
        if (w_entry) begin
            w_ch_cur    = (int'(i_sel) < NCH) ? i_sel : '0;
            w_dwell_cur = '0;
            w_first_cur = (w_ch_cur == '0);
        end
    end

    // Next scan state: blank reloads, auto steps unless held, manual freezes.
    always_comb begin
        w_ch_n    = r_ch_q;
        w_dwell_n = r_dwell_q;
        w_first_n = r_first_q;
        if (i_en) begin
            w_ch_n    = '0;
            w_dwell_n = '0;
            w_first_n = 1'b1;
        end else if (i_mode == MODE_AUTO) begin
            w_ch_n    = w_ch_cur;
            w_dwell_n = w_dwell_cur;
            w_first_n = 1'b0;
            if (!i_hold) begin
                if (w_dwell_cur == DWELL_LAST) begin
                    w_dwell_n = '0;
                    if (w_ch_cur == CH_LAST) begin
                        w_ch_n    = '0;
                        w_first_n = 1'b1;
                    end else begin
                        w_ch_n = w_ch_cur + 1'b1;
                    end
                end else begin
                    w_dwell_n = w_dwell_cur + 1'b1;
                end
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_q    <= '0;
            r_dwell_q <= '0;
            r_first_q <= 1'b1;
            r_mode_d  <= MODE_MANUAL;
        end else begin
            r_ch_q    <= w_ch_n;
            r_dwell_q <= w_dwell_n;
            r_first_q <= w_first_n;
            r_mode_d  <= i_mode;
        end
    end

    assign o_ch_cur    = w_ch_cur;
    assign o_first_cur = w_first_cur;

endmodule

// File: rtl/tdm_mux.sv
// Registered N-channel selector with manual select and auto time-division scan.
// Define TDM_MUX_PARITY_EN to add the registered z_par output.
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int DWELL = 4
) (
    input  logic     clk,
    input  logic     rst,
    tdm_mux_if.slave bus
);
    localparam int SELW  = clog2(NCH);
    localparam int NSLOT = 1 << SELW;

    logic [WIDTH-1:0] w_chan [NSLOT];

    logic [SELW-1:0]  w_ch_cur;
    logic             w_first_cur;
    logic             w_sel_ok;

    logic [WIDTH-1:0] w_z_n;
    logic             w_z_valid_n;
    logic [SELW-1:0]  w_ch_n;
    logic             w_frame_start_n;

    logic [WIDTH-1:0] r_z;
    logic             r_z_valid;
    logic [SELW-1:0]  r_ch;
    logic             r_frame_start;

    // Unused slots of a non-power-of-two channel count read as zero.
    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
        if (k < NCH) begin : g_real
            assign w_chan[k] = bus.din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_chan[k] = '0;
        end
    end

    tdm_scan_ctr #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .i_en        (bus.en),
        .i_mode      (bus.mode),
        .i_sel       (bus.sel),
        .i_hold      (bus.hold),
        .o_ch_cur    (w_ch_cur),
        .o_first_cur (w_first_cur)
    );

    // Next output word: blank beats mode; manual out-of-range select is not valid data.
    always_comb begin
        w_sel_ok        = (int'(bus.sel) < NCH);
        w_z_n           = '0;
        w_z_valid_n     = 1'b0;
        w_ch_n          = r_ch;
        w_frame_start_n = 1'b0;
        if (!bus.en) begin
            if (bus.mode == MODE_AUTO) begin
                w_z_n           = w_chan[w_ch_cur];
                w_z_valid_n     = 1'b1;
                w_ch_n          = w_ch_cur;
                w_frame_start_n = w_first_cur;
            end else begin
                w_ch_n = bus.sel;
                if (w_sel_ok) begin
                    w_z_n       = w_chan[bus.sel];
                    w_z_valid_n = 1'b1;
                end
            end
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z           <= '0;
            r_z_valid     <= 1'b0;
            r_ch          <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_z           <= w_z_n;
            r_z_valid     <= w_z_valid_n;
            r_ch          <= w_ch_n;
            r_frame_start <= w_frame_start_n;
        end
    end

    assign bus.z           = r_z;
    assign bus.z_valid     = r_z_valid;
    assign bus.ch          = r_ch;
    assign bus.frame_start = r_frame_start;

`ifdef TDM_MUX_PARITY_EN
    logic r_z_par;

    // Parity tracks z in the same register stage and is forced low when z is not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z_par <= 1'b0;
        end else begin
            r_z_par <= (^w_z_n) & w_z_valid_n;
        end
    end

    assign bus.z_par = r_z_par;
`endif

endmodule
